// File: rtl/vxe_txnreq_dec_fifo.sv
// Request decoder feeding a FWFT queue; accept at edge N is visible at the head after edge N, with no bypass.
// o_rdy is low only when full (it is a function of state alone); the head holds steady while the consumer stalls.
module vxe_txnreq_dec_fifo #(
  parameter  int TXNID_W = 6,
  parameter  int ADDR_W  = 37,
  parameter  int DATA_W  = 64,
  parameter  int DEPTH   = 4,
  parameter  int CNT_W   = 8,
  localparam int BEN_W   = DATA_W / 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [TXNID_W+ADDR_W:0]     i_req_vec_txn,
  input  logic [DATA_W+BEN_W-1:0]     i_req_vec_dat,
  input  logic                        i_vld,
  output logic                        o_rdy,
  output logic                        o_vld,
  input  logic                        i_rdy,
  output logic [TXNID_W-1:0]          o_txnid,
  output logic                        o_rnw,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W-1:0]           o_data,
  output logic [BEN_W-1:0]            o_ben,
  output logic [LVL_W-1:0]            o_level,
  output logic                        o_drop,
  output logic [CNT_W-1:0]            o_drop_cnt
);

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic               rnw;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [BEN_W-1:0]   ben;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             entry_d;
  entry_t             head;
  logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               full, empty, accept, push, pop;

  // Wrap bits differ with equal indices means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  always_comb begin
    entry_d       = '0;
    entry_d.txnid = i_req_vec_txn[TXNID_W+ADDR_W -: TXNID_W];
    entry_d.rnw   = i_req_vec_txn[ADDR_W];
    entry_d.addr  = i_req_vec_txn[ADDR_W-1:0];
    // Reads never carry payload downstream.
    if (!entry_d.rnw) begin
      entry_d.ben  = i_req_vec_dat[DATA_W+BEN_W-1 -: BEN_W];
      entry_d.data = i_req_vec_dat[DATA_W-1:0];
    end
  end

  always_comb begin
    accept     = i_vld && !full;
    drop_d     = accept && !entry_d.rnw && (entry_d.ben == '0);
    push       = accept && !drop_d;
    pop        = !empty && i_rdy;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drop_cnt_d = (drop_d && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_d;
  end

  // Outputs read zero while empty so stale storage never leaks out.
  always_comb begin
    head    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    o_txnid = head.txnid;
    o_rnw   = head.rnw;
    o_addr  = head.addr;
    o_data  = head.data;
    o_ben   = head.ben;
  end

  assign o_rdy      = !full;
  assign o_vld      = !empty;
  assign o_level    = wr_ptr_q - rd_ptr_q;
  assign o_drop     = drop_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_vxe_txnreq_dec_fifo.sv
// Directed bench for vxe_txnreq_dec_fifo at default parameters; inputs change and outputs are sampled on the falling edge.
module tb_vxe_txnreq_dec_fifo;

  logic        clk = 1'b0;
  logic        nrst;
  logic [43:0] i_req_vec_txn;
  logic [71:0] i_req_vec_dat;
  logic        i_vld, i_rdy;
  logic        o_rdy, o_vld, o_rnw, o_drop;
  logic [5:0]  o_txnid;
  logic [36:0] o_addr;
  logic [63:0] o_data;
  logic [7:0]  o_ben;
  logic [2:0]  o_level;
  logic [7:0]  o_drop_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vxe_txnreq_dec_fifo dut (
    .clk(clk), .nrst(nrst),
    .i_req_vec_txn(i_req_vec_txn), .i_req_vec_dat(i_req_vec_dat),
    .i_vld(i_vld), .o_rdy(o_rdy), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_txnid(o_txnid), .o_rnw(o_rnw), .o_addr(o_addr), .o_data(o_data),
    .o_ben(o_ben), .o_level(o_level), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input logic [5:0] id, input logic rnw, input logic [36:0] addr,
                         input logic [7:0] ben, input logic [63:0] data);
    i_req_vec_txn = {id, rnw, addr};
    i_req_vec_dat = {ben, data};
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    nrst  = 1'b0;
    i_vld = 1'b0;
    i_rdy = 1'b0;
    set_req(6'h0, 1'b0, 37'h0, 8'h0, 64'h0);
    #12;
    chk("rst_vld", o_vld, 0);
    chk("rst_level", o_level, 0);
    chk("rst_rdy", o_rdy, 1);
    chk("rst_drop", o_drop, 0);
    chk("rst_cnt", o_drop_cnt, 0);
    chk("rst_data", o_data, 0);
    step();
    nrst = 1'b1;

    // Single write
    step();
    set_req(6'h2A, 1'b0, 37'h1_2345_6789, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    i_vld = 1'b1; i_rdy = 1'b1;
    chk("wr_no_bypass", o_vld, 0);
    step();
    i_vld = 1'b0;
    chk("wr_vld", o_vld, 1);
    chk("wr_txnid", o_txnid, 6'h2A);
    chk("wr_rnw", o_rnw, 0);
    chk("wr_addr", o_addr, 37'h1_2345_6789);
    chk("wr_data", o_data, 64'hDEADBEEF_CAFEF00D);
    chk("wr_ben", o_ben, 8'hFF);
    chk("wr_level1", o_level, 1);
    step();
    chk("wr_level0", o_level, 0);
    chk("wr_vld0", o_vld, 0);

    // Read: payload masked
    set_req(6'h15, 1'b1, 37'h0_0000_0ABC, 8'hF0, 64'h1122334455667788);
    i_vld = 1'b1;
    step();
    i_vld = 1'b0;
    chk("rd_vld", o_vld, 1);
    chk("rd_rnw", o_rnw, 1);
    chk("rd_data", o_data, 0);
    chk("rd_ben", o_ben, 0);
    chk("rd_txnid", o_txnid, 6'h15);
    chk("rd_addr", o_addr, 37'h0_0000_0ABC);
    step();

    // Zero-ben write dropped
    set_req(6'h07, 1'b0, 37'h40, 8'h00, 64'h55);
    i_vld = 1'b1;
    chk("drop_rdy", o_rdy, 1);
    step();
    i_vld = 1'b0;
    chk("drop_pulse", o_drop, 1);
    chk("drop_vld", o_vld, 0);
    chk("drop_cnt1", o_drop_cnt, 1);
    chk("drop_level", o_level, 0);
    step();
    chk("drop_pulse_end", o_drop, 0);
    i_vld = 1'b1;
    for (int k = 0; k < 300; k++) step();
    i_vld = 1'b0;
    chk("drop_sat", o_drop_cnt, 8'hFF);
    step();
    chk("drop_sat_hold", o_drop_cnt, 8'hFF);
    chk("drop_sat_pulse_end", o_drop, 0);

    // Fill to full with consumer stalled
    i_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_req(6'(k), 1'b0, 37'(k * 16), 8'h0F, 64'(k));
      i_vld = 1'b1;
      step();
    end
    chk("full_rdy", o_rdy, 0);
    chk("full_level", o_level, 4);
    chk("full_head", o_txnid, 1);
    set_req(6'd5, 1'b0, 37'd80, 8'h0F, 64'd5);
    step(); step();
    chk("full_hold_level", o_level, 4);
    chk("full_hold_head", o_txnid, 1);
    chk("full_hold_data", o_data, 1);
    i_rdy = 1'b1;
    step();
    chk("drain_head2", o_txnid, 2);
    chk("drain_level3a", o_level, 3);
    chk("drain_rdy", o_rdy, 1);
    step();
    i_vld = 1'b0;
    chk("drain_head3", o_txnid, 3);
    chk("drain_level3b", o_level, 3);
    step();
    chk("drain_head4", o_txnid, 4);
    chk("drain_level2", o_level, 2);
    step();
    chk("drain_head5", o_txnid, 5);
    chk("drain_addr5", o_addr, 80);
    chk("drain_level1", o_level, 1);
    step();
    chk("drain_empty", o_vld, 0);
    chk("drain_level0", o_level, 0);

    // Streaming: one entry per cycle through wrapping pointers
    i_vld = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        chk("stream_vld", o_vld, 1);
        chk("stream_id", o_txnid, 6'(k - 1));
        chk("stream_level", o_level, 1);
      end
      set_req(6'(k), 1'b0, 37'(k), 8'h01, 64'(k * 3));
      step();
    end
    i_vld = 1'b0;
    chk("stream_last_id", o_txnid, 15);
    chk("stream_last_data", o_data, 45);
    step();
    chk("stream_empty", o_vld, 0);

    // Asynchronous reset with entries queued
    i_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(6'(k + 40), 1'b0, 37'h100, 8'h80, 64'hAB);
      i_vld = 1'b1;
      step();
    end
    i_vld = 1'b0;
    chk("prerst_level", o_level, 3);
    chk("prerst_cnt", o_drop_cnt, 8'hFF);
    #2 nrst = 1'b0;
    #1;
    chk("arst_vld", o_vld, 0);
    chk("arst_level", o_level, 0);
    chk("arst_cnt", o_drop_cnt, 0);
    step();
    nrst = 1'b1;
    step();
    set_req(6'h33, 1'b1, 37'h1F_0000_0001, 8'hAA, 64'hFFFF);
    i_vld = 1'b1; i_rdy = 1'b1;
    step();
    i_vld = 1'b0;
    chk("post_vld", o_vld, 1);
    chk("post_txnid", o_txnid, 6'h33);
    chk("post_rnw", o_rnw, 1);
    chk("post_addr", o_addr, 37'h1F_0000_0001);
    chk("post_data", o_data, 0);
    chk("post_level", o_level, 1);
    step();
    chk("post_empty", o_vld, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
